// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word reads over req/ack, and buffers {pc, word} for decode.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirects raise misalign and halt issue until an aligned redirect.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        misalign
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          drop_q, drop_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          halt_d;

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   word_mem [DEPTH];

    logic          xfer;
    logic          push;
    logic          pop;
    logic [31:0]   redir_tgt;
    logic [31:0]   pc_src;

`ifdef FETCH_ALIGN_CHECK_EN
    logic halt_q;

    always_comb begin
        halt_d = halt_q;
        if (redirect_valid) begin
            halt_d = |redirect_pc[1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end

    assign misalign = halt_q;
`else
    assign halt_d = 1'b0;
`endif

    assign xfer       = req_q & imem_ack;
    // A redirect discards whatever arrives in its own cycle.
    assign push       = xfer & ~drop_q & ~redirect_valid;
    assign inst_valid = (count_q != '0);
    assign pop        = inst_valid & inst_ready;
    assign redir_tgt  = redirect_pc & ~32'h3;
    assign pc_src     = redirect_valid ? redir_tgt : fetch_pc_q;

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign inst       = inst_valid ? word_mem[rd_ptr_q] : '0;
    assign inst_pc    = inst_valid ? pc_mem[rd_ptr_q]   : '0;

    always_comb begin
        req_d      = req_q;
        addr_d     = addr_q;
        fetch_pc_d = pc_src;
        drop_d     = drop_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            count_d = count_q + CW'(push) - CW'(pop);
        end

        if (redirect_valid && req_q && !imem_ack) begin
            drop_d = 1'b1;
        end else if (xfer) begin
            drop_d = 1'b0;
        end

        if (xfer) begin
            req_d = 1'b0;
        end

        // Issue only when the bus is free after this edge and the response is guaranteed a slot.
        if ((!req_q || xfer) && (count_d < DEPTH_C) && !halt_d) begin
            req_d      = 1'b1;
            addr_d     = pc_src;
            fetch_pc_d = pc_src + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            drop_q     <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            req_q      <= req_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= addr_q;
            word_mem[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory returns the bitwise inverse of the address, ack zero-wait or manual.
// Build with FETCH_ALIGN_CHECK_EN defined to exercise the misalign halt path.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign;
`endif

    logic auto_ack;
    logic man_ack;
    int   tests;
    int   fails;
    int   nxfer;

    fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .misalign      (misalign)
`endif
    );

    assign imem_ack   = imem_req & (auto_ack | man_ack);
    assign imem_rdata = ~imem_addr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input logic ready);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        man_ack        = 1'b0;
        inst_ready     = ready;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        auto_ack = 1'b1;
        man_ack  = 1'b0;
        rst      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b1;

        // Reset state
        tick();
        chk("rst_req",   imem_req,   32'd0);
        chk("rst_addr",  imem_addr,  32'h0);
        chk("rst_valid", inst_valid, 32'd0);
        chk("rst_inst",  inst,       32'h0);
        chk("rst_pc",    inst_pc,    32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("rst_misalign", misalign, 32'd0);
`endif

        // Zero-wait streaming from reset
        do_reset(1'b1);
        tick();
        chk("s_req1",   imem_req,   32'd1);
        chk("s_addr1",  imem_addr,  32'h0);
        chk("s_valid1", inst_valid, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("s_valid", inst_valid, 32'd1);
            chk("s_pc",    inst_pc,    32'(4 * i));
            chk("s_inst",  inst,       ~32'(4 * i));
            chk("s_req",   imem_req,   32'd1);
        end

        // Backpressure: fills to DEPTH then stops requesting
        do_reset(1'b0);
        nxfer = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (imem_req && imem_ack) nxfer++;
        end
        chk("bp_xfers", 32'(nxfer), 32'd4);
        chk("bp_req",   imem_req,   32'd0);
        chk("bp_valid", inst_valid, 32'd1);
        chk("bp_head",  inst_pc,    32'h0);
        inst_ready = 1'b1;
        tick();
        chk("bp_resume_req",  imem_req,  32'd1);
        chk("bp_resume_addr", imem_addr, 32'h10);
        chk("bp_pc1",         inst_pc,   32'h4);
        for (int j = 2; j < 5; j++) begin
            tick();
            chk("bp_order", inst_pc, 32'(4 * j));
        end

        // Asynchronous reset while a request is outstanding
        chk("async_pre_req", imem_req, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_req",   imem_req,   32'd0);
        chk("async_addr",  imem_addr,  32'h0);
        chk("async_valid", inst_valid, 32'd0);

        // Delayed ack with redirect during wait cycle 1
        auto_ack = 1'b0;
        do_reset(1'b1);
        tick();
        chk("dl_req1",  imem_req,  32'd1);
        chk("dl_addr1", imem_addr, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        chk("dl_hold2",  imem_addr,  32'h0);
        chk("dl_req2",   imem_req,   32'd1);
        chk("dl_valid2", inst_valid, 32'd0);
        tick();
        chk("dl_hold3",  imem_addr,  32'h0);
        chk("dl_valid3", inst_valid, 32'd0);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        chk("dl_newreq",  imem_req,   32'd1);
        chk("dl_newaddr", imem_addr,  32'h100);
        chk("dl_dropped", inst_valid, 32'd0);
        auto_ack = 1'b1;
        tick();
        chk("dl_valid5", inst_valid, 32'd1);
        chk("dl_pc5",    inst_pc,    32'h100);
        chk("dl_inst5",  inst,       ~32'h100);

        // Redirect coinciding with pop and ack
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        chk("rpa_valid", inst_valid, 32'd0);
        chk("rpa_req",   imem_req,   32'd1);
        chk("rpa_addr",  imem_addr,  32'h40);
        tick();
        chk("rpa_valid2", inst_valid, 32'd1);
        chk("rpa_pc",     inst_pc,    32'h40);

        // PC wraparound
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr2", imem_addr, 32'h0000_0000);
        chk("wrap_pc",    inst_pc,   32'hFFFF_FFFC);

        // Misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick();
        redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        chk("ma_flag",  misalign,   32'd1);
        chk("ma_req",   imem_req,   32'd0);
        chk("ma_valid", inst_valid, 32'd0);
        tick();
        chk("ma_flag2", misalign,   32'd1);
        chk("ma_req2",  imem_req,   32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        chk("ma_clear", misalign,  32'd0);
        chk("ma_rreq",  imem_req,  32'd1);
        chk("ma_raddr", imem_addr, 32'h200);
        tick();
        chk("ma_pc", inst_pc, 32'h200);
`else
        chk("ma_req",   imem_req,   32'd1);
        chk("ma_addr",  imem_addr,  32'h100);
        chk("ma_valid", inst_valid, 32'd0);
        tick();
        chk("ma_pc", inst_pc, 32'h100);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
